cond_branch_unit: RTL and testbench
===================================

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, pipeline-flush pulse length in cycles after a taken branch (legal 0..7).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flag_we  input  1  ALU flag write strobe.
REQ-005 SHALL have port flags_in  input  4  ALU flags {N,Z,C,V}, bit 3 = N.
REQ-006 SHALL have port br_valid  input  1  branch request valid.
REQ-007 SHALL have port br_ready  output  1  unit can accept a request.
REQ-008 SHALL have port br_cond  input  4  condition code.
REQ-009 SHALL have port br_pc  input  16  branch instruction address.
REQ-010 SHALL have port br_off  input  8  signed word offset.
REQ-011 SHALL have port res_valid  output  1  one-cycle result strobe.
REQ-012 SHALL have port res_taken  output  1  condition satisfied.
REQ-013 SHALL have port res_target  output  16  next PC.
REQ-014 SHALL have port flush  output  1  pipeline flush request.
REQ-015 SHALL have port flags_q  output  4  architectural flag register {N,Z,C,V}.

Function
REQ-016 SHALL load flags_q from flags_in on every rising clk with flag_we=1; otherwise hold.
REQ-017 SHALL implement FSM states IDLE, RESP, FLUSH; br_ready=1 only in IDLE.
REQ-018 SHALL accept a request in IDLE when br_valid=1, latch cond/pc/off, go to RESP.
REQ-019 SHALL, in RESP, drive res_valid=1 for exactly one cycle with res_taken/res_target of the latched request (latency 1 cycle from acceptance).
REQ-020 SHALL evaluate conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-021 SHALL, when flag_we=1 in the acceptance cycle, evaluate with flags_in (bypass), else with flags_q.
REQ-022 SHALL compute res_target = br_pc + 1 + sign_extend(br_off) modulo 2^16 when taken (wrap-around, no error), br_pc + 1 modulo 2^16 when not taken.
REQ-023 SHALL go RESP->FLUSH when taken and FLUSH_CYCLES>0, else RESP->IDLE.
REQ-024 SHALL assert flush for exactly FLUSH_CYCLES consecutive cycles in FLUSH, via a down-counter, then return to IDLE.
REQ-025 SHALL hold res_taken and res_target stable outside RESP (last value) and res_valid=0 outside RESP.
REQ-026 SHALL ignore br_valid while br_ready=0; requester holds request until accepted.

Reset
REQ-027 SHALL on rst=0, regardless of state (including mid-FLUSH), force IDLE, flags_q=0, res_valid=0, res_taken=0, res_target=0, flush=0, flush counter=0, latched request=0.
REQ-028 SHALL assert br_ready on the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with COND_BRANCH_STATS_EN defined, add outputs taken_cnt[15:0] and nottaken_cnt[15:0], reset to 0, incremented once per RESP cycle, saturating at 16'hFFFF.
REQ-030 SHALL, without COND_BRANCH_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-031 SHALL place the condition-code enumeration (EQ..NV), flag bit-index constants and FSM state encoding in shared package cpu_flags_pkg.
REQ-032 SHALL implement condition evaluation as combinational sub-module cond_eval (inputs cond[3:0], flags[3:0]; output taken).

Verification
REQ-033 SHALL cover: flag_we with 4'b0100, then EQ at pc=16'h0010, off=8'h05 -> res_taken=1, res_target=16'h0016, flush high 2 cycles.
REQ-034 SHALL cover: flags=4'b0000, EQ at pc=16'h0010 -> res_taken=0, res_target=16'h0011, flush never asserted, br_ready back next cycle.
REQ-035 SHALL cover: pc=16'hFFFF, AL, off=8'h00 -> res_target=16'h0000; pc=16'h0000, off=8'hFE -> res_target=16'hFFFF.
REQ-036 SHALL cover: flag_we with 4'b1000 in same cycle as LT request while flags_q=0 -> res_taken=1 (bypass).
REQ-037 SHALL cover: rst=0 during second flush cycle -> flush=0 immediately, IDLE, br_ready=1 after release.
REQ-038 SHALL cover: all 16 conditions against flags 4'b1001 and 4'b0110 -> results match REQ-020 table; NV never taken.

Source files
------------

// File: rtl/cpu_flags_pkg.sv
// Shared definitions for the conditional-branch unit: condition codes,
// flag bit positions inside {N,Z,C,V}, and the branch FSM state encoding.
package cpu_flags_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a branch with the
// given condition is taken for a {N,Z,C,V} flag vector.
module cond_eval
  import cpu_flags_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Conditional-branch resolution unit with architectural flag register and
// post-branch flush pulse. Optional statistics counters: COND_BRANCH_STATS_EN.
//
// state    | meaning
// ST_IDLE  | ready, waiting for a branch request
// ST_RESP  | one-cycle result strobe for the latched request
// ST_FLUSH | flush asserted while the down-counter runs out
module cond_branch_unit
  import cpu_flags_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_we,
  input  logic [3:0]  flags_in,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_cond,
  input  logic [15:0] br_pc,
  input  logic [7:0]  br_off,
  output logic        res_valid,
  output logic        res_taken,
  output logic [15:0] res_target,
  output logic        flush,
`ifdef COND_BRANCH_STATS_EN
  output logic [15:0] taken_cnt,
  output logic [15:0] nottaken_cnt,
`endif
  output logic [3:0]  flags_q
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_e      state, state_nxt;
  logic [2:0]  flush_cnt;
  logic        flush_load;
  logic [3:0]  lat_cond;
  logic [3:0]  lat_flags;
  logic [15:0] lat_pc;
  logic [7:0]  lat_off;
  logic [3:0]  eval_flags;
  logic        accept;
  logic        taken;
  logic [15:0] target;
  logic        hold_taken;
  logic [15:0] hold_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         flags_q <= 4'd0;
    else if (flag_we) flags_q <= flags_in;
  end

  // A flag write in the acceptance cycle is visible to that same branch.
  assign eval_flags = flag_we ? flags_in : flags_q;
  assign accept     = (state == ST_IDLE) && br_valid;

  cond_eval u_cond_eval (
    .cond  (lat_cond),
    .flags (lat_flags),
    .taken (taken)
  );

  assign target = taken ? (lat_pc + 16'd1 + {{8{lat_off[7]}}, lat_off})
                        : (lat_pc + 16'd1);

  always_comb begin
    state_nxt  = state;
    br_ready   = 1'b0;
    res_valid  = 1'b0;
    flush      = 1'b0;
    flush_load = 1'b0;
    res_taken  = hold_taken;
    res_target = hold_target;
    case (state)
      ST_IDLE: begin
        br_ready = 1'b1;
        if (br_valid) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        res_valid  = 1'b1;
        res_taken  = taken;
        res_target = target;
        if (taken && (FLUSH_CYCLES > 0)) begin
          state_nxt  = ST_FLUSH;
          flush_load = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == 3'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      flush_cnt   <= 3'd0;
      lat_cond    <= 4'd0;
      lat_flags   <= 4'd0;
      lat_pc      <= 16'd0;
      lat_off     <= 8'd0;
      hold_taken  <= 1'b0;
      hold_target <= 16'd0;
    end else begin
      state <= state_nxt;
      if (flush_load)              flush_cnt <= FLUSH_INIT;
      else if (state == ST_FLUSH)  flush_cnt <= flush_cnt - 3'd1;
      if (accept) begin
        lat_cond  <= br_cond;
        lat_flags <= eval_flags;
        lat_pc    <= br_pc;
        lat_off   <= br_off;
      end
      // Results stay on the outputs until the next request resolves.
      if (state == ST_RESP) begin
        hold_taken  <= taken;
        hold_target <= target;
      end
    end
  end

`ifdef COND_BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_cnt    <= 16'd0;
      nottaken_cnt <= 16'd0;
    end else if (state == ST_RESP) begin
      if (taken && (taken_cnt != 16'hFFFF))
        taken_cnt <= taken_cnt + 16'd1;
      else if (!taken && (nottaken_cnt != 16'hFFFF))
        nottaken_cnt <= nottaken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed self-checking bench for cond_branch_unit (default build, FLUSH_CYCLES=2).
module tb_cond_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_we;
  logic [3:0]  flags_in;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [15:0] br_pc;
  logic [7:0]  br_off;
  logic        res_valid;
  logic        res_taken;
  logic [15:0] res_target;
  logic        flush;
  logic [3:0]  flags_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_branch_unit #(.FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_we    (flag_we),
    .flags_in   (flags_in),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_cond    (br_cond),
    .br_pc      (br_pc),
    .br_off     (br_off),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_target (res_target),
    .flush      (flush),
    .flags_q    (flags_q)
  );

  // Called just after a negedge; returns just after the next negedge.
  task automatic send(input logic [3:0] c, input logic [15:0] pc, input logic [7:0] off,
                      input logic we, input logic [3:0] fl);
    br_valid = 1'b1; br_cond = c; br_pc = pc; br_off = off;
    flag_we = we; flags_in = fl;
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0; flag_we = 1'b0;
  endtask

  task automatic write_flags(input logic [3:0] fl);
    flag_we = 1'b1; flags_in = fl;
    @(posedge clk);
    @(negedge clk);
    flag_we = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (br_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; flag_we = 0; flags_in = 0; br_valid = 0; br_cond = 0; br_pc = 0; br_off = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", br_ready); end
    checks++; if (flags_q !== 4'd0) begin errors++; $display("FAIL reset_flags got=%h exp=0", flags_q); end
    checks++; if ({res_valid, res_taken, flush} !== 3'b000) begin errors++; $display("FAIL reset_outs got=%b exp=000", {res_valid, res_taken, flush}); end
    checks++; if (res_target !== 16'h0000) begin errors++; $display("FAIL reset_target got=%h exp=0000", res_target); end
  endtask

  task automatic test_taken_flush;
    write_flags(4'b0100);
    checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL flag_load got=%b exp=0100", flags_q); end
    send(4'd0, 16'h0010, 8'h05, 1'b0, 4'b0000);
    checks++; if ({res_valid, res_taken, br_ready, flush} !== 4'b1100) begin errors++; $display("FAIL taken_resp got=%b exp=1100", {res_valid, res_taken, br_ready, flush}); end
    checks++; if (res_target !== 16'h0016) begin errors++; $display("FAIL taken_target got=%h exp=0016", res_target); end
    @(negedge clk);
    checks++; if ({flush, res_valid, br_ready} !== 3'b100) begin errors++; $display("FAIL flush1 got=%b exp=100", {flush, res_valid, br_ready}); end
    checks++; if ({res_taken, res_target} !== {1'b1, 16'h0016}) begin errors++; $display("FAIL result_hold got=%b/%h exp=1/0016", res_taken, res_target); end
    @(negedge clk);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL flush2 got=%b exp=1", flush); end
    @(negedge clk);
    checks++; if ({flush, br_ready} !== 2'b01) begin errors++; $display("FAIL flush_end got=%b exp=01", {flush, br_ready}); end
  endtask

  task automatic test_not_taken;
    bit saw_flush;
    write_flags(4'b0000);
    send(4'd0, 16'h0010, 8'h05, 1'b0, 4'b0000);
    saw_flush = flush;
    checks++; if ({res_valid, res_taken} !== 2'b10) begin errors++; $display("FAIL nt_resp got=%b exp=10", {res_valid, res_taken}); end
    checks++; if (res_target !== 16'h0011) begin errors++; $display("FAIL nt_target got=%h exp=0011", res_target); end
    @(negedge clk);
    saw_flush |= flush;
    checks++; if ({br_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL nt_ready got=%b exp=10", {br_ready, res_valid}); end
    @(negedge clk);
    saw_flush |= flush;
    checks++; if (saw_flush !== 1'b0) begin errors++; $display("FAIL nt_flush got=%b exp=0", saw_flush); end
  endtask

  task automatic test_wrap;
    bit ok;
    send(4'd14, 16'hFFFF, 8'h00, 1'b0, 4'b0000);
    checks++; if ({res_valid, res_taken, res_target} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL wrap_hi got=%b%b/%h exp=11/0000", res_valid, res_taken, res_target); end
    @(negedge clk);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_idle_timeout got=0 exp=1"); end
    send(4'd14, 16'h0000, 8'hFE, 1'b0, 4'b0000);
    checks++; if ({res_valid, res_taken, res_target} !== {2'b11, 16'hFFFF}) begin errors++; $display("FAIL wrap_lo got=%b%b/%h exp=11/ffff", res_valid, res_taken, res_target); end
    @(negedge clk);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_idle2_timeout got=0 exp=1"); end
  endtask

  task automatic test_bypass;
    bit ok;
    write_flags(4'b0000);
    send(4'd11, 16'h0200, 8'h10, 1'b1, 4'b1000);
    checks++; if ({res_valid, res_taken} !== 2'b11) begin errors++; $display("FAIL bypass_taken got=%b exp=11", {res_valid, res_taken}); end
    checks++; if (res_target !== 16'h0211) begin errors++; $display("FAIL bypass_target got=%h exp=0211", res_target); end
    checks++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL bypass_flags got=%b exp=1000", flags_q); end
    @(negedge clk);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bypass_idle_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset_mid_flush;
    send(4'd0, 16'h0300, 8'h04, 1'b1, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mid_flush_pre got=%b exp=1", flush); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({flush, br_ready, res_valid} !== 3'b010) begin errors++; $display("FAIL mid_flush_rst got=%b exp=010", {flush, br_ready, res_valid}); end
    checks++; if ({flags_q, res_taken, res_target} !== 21'd0) begin errors++; $display("FAIL mid_flush_clear got=%h/%b/%h exp=0/0/0000", flags_q, res_taken, res_target); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({br_ready, flush} !== 2'b10) begin errors++; $display("FAIL post_rst_ready got=%b exp=10", {br_ready, flush}); end
  endtask

  task automatic test_all_conds;
    logic [3:0]  fl [2];
    logic [15:0] exp_vec [2];
    logic [15:0] ev, pc, tgt;
    bit ok;
    fl[0] = 4'b1001; exp_vec[0] = 16'h565A;
    fl[1] = 4'b0110; exp_vec[1] = 16'h66A5;
    for (int s = 0; s < 2; s++) begin
      ev = exp_vec[s];
      for (int c = 0; c < 16; c++) begin
        pc  = 16'h0100 + 16'(c);
        tgt = ev[c] ? pc + 16'd17 : pc + 16'd1;
        send(4'(c), pc, 8'h10, 1'b1, fl[s]);
        checks++;
        if ({res_valid, res_taken, res_target} !== {1'b1, ev[c], tgt}) begin
          errors++;
          $display("FAIL cond_%0d_flags_%b got=%b%b/%h exp=1%b/%h", c, fl[s], res_valid, res_taken, res_target, ev[c], tgt);
        end
        @(negedge clk);
        wait_idle(ok);
        if (!ok) begin errors++; $display("FAIL cond_idle_timeout got=0 exp=1"); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] seen;
    bit ok;
    br_valid = 1'b1; br_cond = 4'd14; br_pc = 16'h0400; br_off = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen[i] = res_valid;
    end
    br_valid = 1'b0;
    checks++; if (seen !== 5'b10001) begin errors++; $display("FAIL held_request got=%b exp=10001", seen); end
    @(negedge clk);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle_timeout got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_taken_flush();
    test_not_taken();
    test_wrap();
    test_bypass();
    test_reset_mid_flush();
    test_all_conds();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
